// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the memory responder slice.
// This file has no ports. It provides:
//   XLEN    - data word width (32)
//   STRB_W  - byte-strobe width (4)
//   state_t - responder FSM states IDLE, WAIT and RESP
// Configuration macro used elsewhere in this slice: MEM_BYTE_STROBE_EN.
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : riscv_mem_pkg

// File: rtl/mem_responder_mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
// Single-port synchronous word memory with per-byte write mask. The read
// data register is updated on every clock edge. A write and a read of the
// same word on the same edge return the content from before the write.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   wmask  in   STRB_W byte-lane write mask
//   index  in   ADDR_W word index
//   wdata  in   XLEN write data
//   rdata  out  XLEN registered read data
// The contents are never reset.
// ---------------------------------------------------------------------------
module mem_array
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [STRB_W-1:0] wmask,
    input  logic [ADDR_W-1:0] index,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] r_mem [2**ADDR_W];

    // Byte-lane masked write and free-running registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wmask[b]) begin
                    r_mem[index][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= r_mem[index];
    end

endmodule : mem_array

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Fixed-latency memory responder for a simple core bus. It accepts one
// request at a time. The response is presented LATENCY cycles after accept
// and is held until the core consumes it.
// Parameters:
//   ADDR_W  - word index width; the memory holds 2**ADDR_W 32-bit words
//   LATENCY - cycles from accept to resp_valid (1..15)
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   req_valid  in   core presents a request
//   req_ready  out  responder can accept (IDLE only)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_wstrb  in   byte-lane write enables
//   resp_valid out  response available (RESP only)
//   resp_ready in   core consumes the response
//   resp_rdata out  load data, 0 for stores and faults
//   resp_err   out  access fault (misaligned or out of range)
// Configuration macro: MEM_BYTE_STROBE_EN. When it is defined, stores write
// only the lanes enabled in req_wstrb. Otherwise stores write the full word
// and req_wstrb is ignored.
// ---------------------------------------------------------------------------
module mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    state_t              r_state;
    state_t              w_nextState;
    logic [3:0]          r_count;
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_index;
    logic [XLEN-1:0]     r_wdata;

    logic                w_accept;
    logic                w_fault;
    logic                w_enterResp;
    logic                w_useLive;
    logic [ADDR_W-1:0]   w_reqIndex;
    logic                w_memWe;
    logic [STRB_W-1:0]   w_memMask;
    logic [ADDR_W-1:0]   w_memIndex;
    logic [XLEN-1:0]     w_memWdata;
    logic [XLEN-1:0]     w_memRdata;

    assign w_accept   = req_valid & req_ready;
    assign w_reqIndex = req_addr[ADDR_W+1:2];

    // Any set bit above the word index makes the address out of range.
    assign w_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != '0);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and handshake outputs. The edge that enters RESP is also the
    // edge that writes a store and samples a load. With LATENCY=1 that is the
    // accept edge itself. Otherwise it is the WAIT edge at which the counter
    // reaches zero.
    always_comb begin
        w_nextState = r_state;
        w_enterResp = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        resp_rdata  = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_nextState = RESP;
                        w_enterResp = 1'b1;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_count <= 4'd1) begin
                    w_nextState = RESP;
                    w_enterResp = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (r_we || r_err) ? '0 : w_memRdata;
                if (resp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request latch and latency counter. Only an accepted request updates
    // the latch. This prevents a request offered while busy from leaving a
    // trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_index <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_count <= 4'(LATENCY - 1);
            r_we    <= req_we;
            r_err   <= w_fault;
            r_index <= w_reqIndex;
            r_wdata <= req_wdata;
        end else if (r_state == WAIT && r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

`ifdef MEM_BYTE_STROBE_EN
    logic [STRB_W-1:0] r_wstrb;

    // Strobe latch, present only when byte lanes matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_wstrb <= req_wstrb;
        end
    end

    assign w_memMask = w_useLive ? req_wstrb : r_wstrb;
`else
    logic w_unusedWstrb;

    assign w_unusedWstrb = ^req_wstrb;
    assign w_memMask     = '1;
`endif

    // In IDLE the memory sees the live request. The LATENCY=1 access happens
    // on the accept edge, before the latch holds anything. In WAIT and RESP
    // the memory sees the latched request, which keeps the read data steady
    // while the response is held.
    assign w_useLive  = (r_state == IDLE);
    assign w_memIndex = w_useLive ? w_reqIndex : r_index;
    assign w_memWdata = w_useLive ? req_wdata  : r_wdata;

    // A reset on the same edge aborts the pending store.
    assign w_memWe = w_enterResp && !reset &&
                     (w_useLive ? (req_we && !w_fault) : (r_we && !r_err));

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_memArray (
        .clk   (clk),
        .we    (w_memWe),
        .wmask (w_memMask),
        .index (w_memIndex),
        .wdata (w_memWdata),
        .rdata (w_memRdata)
    );

endmodule : mem_responder

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the memory depth to 2**ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal range 1..15, SHALL set the number of cycles from request accept to response valid.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports, in this order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load/fetch
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_wstrb  in  4  byte-lane write enables
- resp_valid  out  1  response available
- resp_ready  in  1  core consumes the response
- resp_rdata  out  32  load data (0 for stores and errors)
- resp_err  out  1  access fault

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-006 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-007 A request SHALL be accepted when req_valid and req_ready are both 1 at a clk edge, and the block SHALL latch addr, we, wdata and wstrb at that edge.
REQ-008 On accept, the FSM SHALL go to WAIT and load the latency counter with LATENCY-1. If LATENCY=1, it SHALL go directly to RESP.
REQ-009 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter is 0.
REQ-010 resp_valid SHALL be 1 exactly in RESP, so the first resp_valid cycle is LATENCY cycles after accept.
REQ-011 resp_valid, resp_rdata and resp_err SHALL stay stable in RESP until resp_ready=1. That edge SHALL return the FSM to IDLE.
REQ-012 There is no back-to-back path: a new request SHALL be accepted no earlier than the cycle after the RESP to IDLE transition.
REQ-013 The word index SHALL be req_addr[ADDR_W+1:2].
REQ-014 An access fault SHALL occur if req_addr[1:0] != 0 or any of req_addr[31:ADDR_W+2] != 0. A fault SHALL set resp_err=1 and resp_rdata=0, and SHALL NOT write memory.
REQ-015 A store SHALL write memory exactly once, on the edge that enters RESP; for a store, resp_rdata SHALL be 0.
REQ-016 A load SHALL return the word content as it stood at the edge entering RESP.
REQ-017 req_valid asserted while req_ready=0 SHALL be ignored, with no latching and no side effects.
REQ-018 resp_ready=1 outside RESP SHALL have no effect.

Reset
REQ-019 While reset=1 at an edge, the block SHALL set state to IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 and counter=0.
REQ-020 A reset asserted in WAIT SHALL abort the access; a pending store SHALL NOT be written.
REQ-021 Memory array contents SHALL NOT be reset.

Configuration
REQ-022 Macro MEM_BYTE_STROBE_EN is the only configuration macro.
REQ-023 With MEM_BYTE_STROBE_EN defined, a store SHALL update only the byte lanes whose req_wstrb bit is 1. A store with wstrb=0000 SHALL complete normally and write nothing.
REQ-024 Without MEM_BYTE_STROBE_EN, req_wstrb SHALL be ignored and every store SHALL write all 32 bits. The port SHALL remain present in both builds.

Structure
REQ-025 Package riscv_mem_pkg SHALL hold:
- the state encoding (IDLE, WAIT, RESP)
- the XLEN=32 width constant
- the 4-bit strobe width constant
REQ-026 The storage SHALL be a sub-module mem_array with a single synchronous port: clk, we, 4-bit byte-write mask, word index, wdata, rdata. mem_responder SHALL own the FSM, the counter and the fault check.

Verification
REQ-027 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 1111, resp_ready=1 -> resp_valid high 2 cycles after accept, err=0, rdata=0. A following load of 0x10 -> rdata 0xDEADBEEF.
REQ-028 Load addr 0x12 (misaligned) -> resp_err=1, rdata=0. Load addr 0x400 with ADDR_W=8 -> resp_err=1, and the word at index 0 is unchanged.
REQ-029 resp_ready held 0 for 5 cycles in RESP -> resp_valid, rdata and err stable for all 5 cycles, req_ready=0, and a req_valid pulse in that window is ignored.
REQ-030 MEM_BYTE_STROBE_EN defined: word 0x20 = 0x11223344, then store 0xAABBCCDD with wstrb 0101 -> load returns 0x11BB33DD. Macro undefined: the same sequence returns 0xAABBCCDD.
REQ-031 Store to 0x30 with reset asserted one cycle after accept (LATENCY=3) -> the block returns to IDLE with req_ready=1 and resp_valid=0, and a later load of 0x30 returns the prior value.
REQ-032 LATENCY=1: load accepted at edge N -> resp_valid=1 in cycle N+1.
